seq_tx: RTL and testbench

Serial pattern transmitter. It is the stimulus-side counterpart of the team's serial sequence detector.
- Loads a parallel word and shifts it out MSB-first as a dout/valid bit stream.
- Supports a programmable frame length, repeat count and inter-frame idle gap.
- Feeds any din/valid serial consumer, e.g. the 1011 overlap detector, and replaces bench-only random drive with deterministic, cycle-exact patterns.

---
 rtl/seq_tx_pkg.sv | 16 +
 rtl/seq_tx_shifter.sv | 31 +++
 rtl/seq_tx.sv | 144 ++++++++++++++
 tb/tb_seq_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the seq_tx serial pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A zero length, or one longer than the data word, selects the full word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned data_w);
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable left-shift register whose output tap sits at a run-time bit position.
module seq_tx_shifter #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  tap_idx,
  output logic              tap
);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign sel = sr >> tap_idx;
  assign tap = sel[0];

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a latched word MSB-first, rep+1 times, with
// an optional idle gap between frames, then pulses done for one cycle.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int REP_W  = 4,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [REP_W-1:0]  rep_in,
  input  logic [GAP_W-1:0]  gap_in,
  output logic              dout,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_cnt;
  logic [REP_W-1:0]  frame_cnt;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;

  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  len_eff_m1;
  logic [LEN_W-1:0]  len_q_m1;
  logic [DATA_W-1:0] first_sel;
  logic [DATA_W-1:0] reload_sel;
  logic              accept;
  logic              reload;
  logic              sh_load;
  logic              sh_shift;
  logic [DATA_W-1:0] sh_data;
  logic              sh_tap;

  assign len_eff    = LEN_W'(eff_len(32'(len_in), DATA_W));
  assign len_eff_m1 = len_eff - LEN_W'(1);
  assign len_q_m1   = len_q - LEN_W'(1);
  assign first_sel  = data_in >> len_eff_m1;
  assign reload_sel = data_q >> len_q_m1;

  assign accept = (state == IDLE) && start;
  assign reload = ((state == SEND) && (bit_cnt == '0) && (frame_cnt != '0) && (gap_q == '0)) ||
                  ((state == GAP) && (gap_cnt == '0));

  // The MSB goes straight to dout on a (re)load, so the shifter is loaded one
  // position ahead and its tap always holds the next bit to send.
  assign sh_load  = accept || reload;
  assign sh_shift = (state == SEND) && (bit_cnt != '0);
  assign sh_data  = accept ? (data_in << 1) : (data_q << 1);

  seq_tx_shifter #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_data),
    .tap_idx   (len_q_m1),
    .tap       (sh_tap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      dout      <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            data_q    <= data_in;
            len_q     <= len_eff;
            frame_cnt <= rep_in;
            gap_q     <= gap_in;
            bit_cnt   <= len_eff_m1;
            dout      <= first_sel[0];
            valid     <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - LEN_W'(1);
            dout    <= sh_tap;
          end else if (frame_cnt != '0) begin
            frame_cnt <= frame_cnt - REP_W'(1);
            if (gap_q != '0) begin
              gap_cnt <= gap_q - GAP_W'(1);
              dout    <= 1'b0;
              valid   <= 1'b0;
              state   <= GAP;
            end else begin
              bit_cnt <= len_q_m1;
              dout    <= reload_sel[0];
            end
          end else begin
            dout  <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else begin
            bit_cnt <= len_q_m1;
            dout    <= reload_sel[0];
            valid   <= 1'b1;
            state   <= SEND;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: directed frames with hand-computed streams feed an expected
// queue of per-cycle {busy,valid,dout,done}; a negedge monitor checks every cycle.
module tb_seq_tx;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int REP_W  = 4;
  localparam int GAP_W  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [LEN_W-1:0]  len_in;
  logic [REP_W-1:0]  rep_in;
  logic [GAP_W-1:0]  gap_in;
  logic              dout;
  logic              valid;
  logic              busy;
  logic              done;

  seq_tx #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .REP_W  (REP_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .len_in  (len_in),
    .rep_in  (rep_in),
    .gap_in  (gap_in),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  // scoreboard state
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         mon_en   = 1'b0;
  logic [2:0] hist;
  int         det_cnt;
  logic [3:0] act_v;
  logic [3:0] exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: idle cycles are expected to read all zeros
  always @(negedge clk) begin
    if (mon_en) begin
      act_v = {busy, valid, dout, done};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle %0d {busy,valid,dout,done}: got %b expected %b", cyc, act_v, exp_v);
      end
      if (valid === 1'b1) begin
        if ({hist, dout} == 4'b1011) det_cnt++;
        hist = {hist[1:0], dout};
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: start a transmission and queue its hand-computed cycle stream
  task automatic launch(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] g, input int ncyc,
                        input logic [31:0] vmask, input logic [31:0] dmask);
    @(negedge clk);
    data_in = d;
    len_in  = l;
    rep_in  = r;
    gap_in  = g;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = ncyc - 1; i >= 0; i--) exp_q.push_back({1'b1, vmask[i], dmask[i], 1'b0});
    exp_q.push_back(4'b1001);
    // latched values must not follow the inputs
    data_in = 8'($urandom_range(0, 255));
    len_in  = 4'($urandom_range(0, 15));
    rep_in  = 4'($urandom_range(0, 15));
    gap_in  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " idle timeout"}, int'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 8'hFF;
    len_in  = '0;
    rep_in  = '0;
    gap_in  = '0;
    hist    = '0;
    det_cnt = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);

    launch(8'h0B, 4'd4, 4'd0, 4'd0, 4, 32'hF, 32'b1011);
    wait_idle("len4");

    hist    = '0;
    det_cnt = 0;
    launch(8'h0B, 4'd4, 4'd2, 4'd0, 12, 32'hFFF, 32'b101110111011);
    wait_idle("rep2");
    check("detector pulses", det_cnt, 3);

    launch(8'h0B, 4'd4, 4'd1, 4'd3, 11, 32'b11110001111, 32'b10110001011);
    wait_idle("gap3");

    launch(8'hA5, 4'd0, 4'd0, 4'd0, 8, 32'hFF, 32'hA5);
    wait_idle("len0");

    launch(8'h3C, 4'd9, 4'd0, 4'd0, 8, 32'hFF, 32'h3C);
    wait_idle("len9");

    launch(8'h96, 4'd15, 4'd0, 4'd0, 8, 32'hFF, 32'h96);
    wait_idle("len15");

    launch(8'h01, 4'd1, 4'd15, 4'd0, 16, 32'hFFFF, 32'hFFFF);
    wait_idle("rep_max");

    launch(8'h02, 4'd2, 4'd1, 4'd1, 5, 32'b11011, 32'b10010);
    wait_idle("gap1");

    // start during SEND and during DONE must be ignored
    launch(8'hA5, 4'd0, 4'd0, 4'd0, 8, 32'hFF, 32'hA5);
    @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      check("done seen", int'(seen), 1);
    end
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("ignored start");

    // reset while the second bit is on the line
    launch(8'hA5, 4'd0, 4'd0, 4'd0, 8, 32'hFF, 32'hA5);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    launch(8'h0B, 4'd4, 4'd0, 4'd0, 4, 32'hF, 32'b1011);
    wait_idle("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
